// File: rtl/max11198_regs_pkg.sv
// -----------------------------------------------------------------------------
// max11198_regs_pkg
// Shared definitions for the MAX11198 AXI4-Lite register block:
//   - byte offsets of every register in the 0x00-0x1C window
//   - AXI response codes
//   - STATUS bit positions
//   - word-index enum (offset bits [4:2]) used by the address decoders
//   - byte-strobe merge helper
// -----------------------------------------------------------------------------
package max11198_regs_pkg;

   localparam logic [4:0] ADDR_REG0   = 5'h00;
   localparam logic [4:0] ADDR_REG1   = 5'h04;
   localparam logic [4:0] ADDR_REG2   = 5'h08;
   localparam logic [4:0] ADDR_REG3   = 5'h0C;
   localparam logic [4:0] ADDR_SAMPLE = 5'h10;
   localparam logic [4:0] ADDR_STATUS = 5'h14;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int STATUS_NEW_BIT = 0;
   localparam int STATUS_OVR_BIT = 1;

   // Word index = byte offset [4:2]; byte-lane bits [1:0] never take part in decode.
   typedef enum logic [2:0] {
      IDX_REG0   = ADDR_REG0[4:2],
      IDX_REG1   = ADDR_REG1[4:2],
      IDX_REG2   = ADDR_REG2[4:2],
      IDX_REG3   = ADDR_REG3[4:2],
      IDX_SAMPLE = ADDR_SAMPLE[4:2],
      IDX_STATUS = ADDR_STATUS[4:2]
   } reg_idx_e;

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] result;
      result = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) result[8*b +: 8] = new_val[8*b +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/max11198_sample_capture.sv
// -----------------------------------------------------------------------------
// max11198_sample_capture
// Holds the most recent ADC sample word and the two sticky STATUS flags.
// Built only when MAX11198_AXIL_SAMPLE_EN is defined.
//   clk, rst        : clock, synchronous active-high reset
//   adc_data        : ADC sample word, qualified by adc_valid
//   adc_valid       : one-cycle capture strobe
//   sample_rd       : SAMPLE register read accepted (clears NEW)
//   ovr_clr         : write-1 to STATUS.OVR committed (clears OVR)
//   sample          : last captured word
//   flag_new        : a sample arrived since SAMPLE was last read
//   flag_ovr        : a sample arrived while the previous one was still unread
// A set event always beats a coincident clear event.
// -----------------------------------------------------------------------------
module max11198_sample_capture (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] adc_data,
   input  logic        adc_valid,
   input  logic        sample_rd,
   input  logic        ovr_clr,
   output logic [15:0] sample,
   output logic        flag_new,
   output logic        flag_ovr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         sample   <= '0;
         flag_new <= 1'b0;
         flag_ovr <= 1'b0;
      end else begin
         if (adc_valid) sample <= adc_data;

         if (adc_valid)      flag_new <= 1'b1;
         else if (sample_rd) flag_new <= 1'b0;

         // OVR looks at the NEW value from before this edge.
         if (adc_valid && flag_new) flag_ovr <= 1'b1;
         else if (ovr_clr)          flag_ovr <= 1'b0;
      end
   end

endmodule

// File: rtl/max11198_axil_regs.sv
// -----------------------------------------------------------------------------
// max11198_axil_regs
// AXI4-Lite slave exposing the MAX11198 control registers.
//   ACLK, ARESET       : clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*    : write channels; AW and W are latched independently
//                        and the write commits once both are held
//   S_AXI_AR*/R*       : read channels; one-cycle registered read latency
//   reg0_o..reg3_o     : live contents of REG0-REG3 for the ADC core
//   adc_data_i,
//   adc_valid_i        : ADC sample interface (only with the macro below)
// Map: 0x00-0x0C REG0-REG3 (RW); with MAX11198_AXIL_SAMPLE_EN defined,
// 0x10 SAMPLE (RO) and 0x14 STATUS (NEW / OVR-W1C). All else -> SLVERR.
// Optional feature macro: MAX11198_AXIL_SAMPLE_EN
// -----------------------------------------------------------------------------
module max11198_axil_regs
   import max11198_regs_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,   // only 32 is supported
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
`ifdef MAX11198_AXIL_SAMPLE_EN
   input  logic [15:0]                     adc_data_i,
   input  logic                            adc_valid_i,
`endif
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o
);

   logic [31:0] regs [4];

   logic        live_q;        // low during reset and the first cycle after it
   logic        aw_latched_q;
   logic [2:0]  aw_idx_q;
   logic        w_latched_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic        bvalid_q;
   logic [1:0]  bresp_q;
   logic        rvalid_q;
   logic [1:0]  rresp_q;
   logic [31:0] rdata_q;

   logic        aw_hs, w_hs, ar_hs, commit, wr_ok;
   logic [2:0]  rd_idx;
   logic [31:0] rd_data;
   logic [1:0]  rd_resp;

   // Protection bits and byte-lane address bits play no part in decode.
   logic unused_bits;
   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = live_q & ~aw_latched_q & ~bvalid_q;
   assign S_AXI_WREADY  = live_q & ~w_latched_q  & ~bvalid_q;
   assign S_AXI_ARREADY = live_q & ~rvalid_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RRESP   = rresp_q;
   assign S_AXI_RDATA   = rdata_q;

   assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
   assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign commit = aw_latched_q & w_latched_q & ~bvalid_q;
   assign rd_idx = S_AXI_ARADDR[4:2];

   assign reg0_o = regs[0];
   assign reg1_o = regs[1];
   assign reg2_o = regs[2];
   assign reg3_o = regs[3];

`ifdef MAX11198_AXIL_SAMPLE_EN
   logic [15:0] sample;
   logic        flag_new, flag_ovr;
   logic        sample_rd, ovr_clr;

   assign sample_rd = ar_hs & (rd_idx == IDX_SAMPLE);
   assign ovr_clr   = commit & (aw_idx_q == IDX_STATUS) & w_strb_q[0]
                    & w_data_q[STATUS_OVR_BIT];

   max11198_sample_capture u_sample_capture (
      .clk       (ACLK),
      .rst       (ARESET),
      .adc_data  (adc_data_i),
      .adc_valid (adc_valid_i),
      .sample_rd (sample_rd),
      .ovr_clr   (ovr_clr),
      .sample    (sample),
      .flag_new  (flag_new),
      .flag_ovr  (flag_ovr)
   );
`endif

   // Write decode: SAMPLE is read-only, so a write there is accepted and ignored.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      wr_ok = 1'b0;
      case (aw_idx_q)
         IDX_REG0, IDX_REG1, IDX_REG2, IDX_REG3: wr_ok = 1'b1;
`ifdef MAX11198_AXIL_SAMPLE_EN
         IDX_SAMPLE, IDX_STATUS:                 wr_ok = 1'b1;
`endif
         default:                                wr_ok = 1'b0;
      endcase
   end

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_SLVERR;
      case (rd_idx)
         IDX_REG0, IDX_REG1, IDX_REG2, IDX_REG3: begin
            rd_data = regs[rd_idx[1:0]];
            rd_resp = RESP_OKAY;
         end
`ifdef MAX11198_AXIL_SAMPLE_EN
         IDX_SAMPLE: begin
            rd_data = {16'h0, sample};
            rd_resp = RESP_OKAY;
         end
         IDX_STATUS: begin
            rd_data[STATUS_NEW_BIT] = flag_new;
            rd_data[STATUS_OVR_BIT] = flag_ovr;
            rd_resp = RESP_OKAY;
         end
`endif
         default: ;
      endcase
   end

   // Write path. The latched halves are held through the response so the
   // readies stay low until the B handshake.
   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         live_q       <= 1'b0;
         aw_latched_q <= 1'b0;
         aw_idx_q     <= '0;
         w_latched_q  <= 1'b0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         bvalid_q     <= 1'b0;
         bresp_q      <= RESP_OKAY;
         // NOTE: the register file is reset because the ADC core sees reg*_o directly.
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else begin
         live_q <= 1'b1;
         if (aw_hs) begin
            aw_latched_q <= 1'b1;
            aw_idx_q     <= S_AXI_AWADDR[4:2];
         end
         if (w_hs) begin
            w_latched_q <= 1'b1;
            w_data_q    <= S_AXI_WDATA;
            w_strb_q    <= S_AXI_WSTRB;
         end
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (!aw_idx_q[2])
               regs[aw_idx_q[1:0]] <= apply_strb(regs[aw_idx_q[1:0]], w_data_q, w_strb_q);
         end
         if (bvalid_q && S_AXI_BREADY) begin
            bvalid_q     <= 1'b0;
            aw_latched_q <= 1'b0;
            w_latched_q  <= 1'b0;
         end
      end
   end

   // Read path. A read captured on the commit edge sees the pre-write value.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rresp_q  <= rd_resp;
         rdata_q  <= rd_data;
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_max11198_axil_regs.sv
// -----------------------------------------------------------------------------
// tb_max11198_axil_regs
// Self-checking bench for max11198_axil_regs. Directed scenarios plus a
// randomized read/write mix checked against a register-array model.
// Define MAX11198_AXIL_SAMPLE_EN for both bench and RTL to cover SAMPLE/STATUS.
// -----------------------------------------------------------------------------
module tb_max11198_axil_regs;

   localparam int          TIMEOUT = 50;
   localparam logic [1:0]  OKAY    = 2'b00;
   localparam logic [1:0]  SLVERR  = 2'b10;

   logic        clk = 1'b0;
   logic        areset;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic [31:0] reg0, reg1, reg2, reg3;
`ifdef MAX11198_AXIL_SAMPLE_EN
   logic [15:0] adc_data;
   logic        adc_valid;
`endif

   int errors = 0;
   int checks = 0;
   logic [31:0] model_regs [4];

   always #5 clk = ~clk;

   max11198_axil_regs dut (
      .ACLK          (clk),
      .ARESET        (areset),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
`ifdef MAX11198_AXIL_SAMPLE_EN
      .adc_data_i    (adc_data),
      .adc_valid_i   (adc_valid),
`endif
      .reg0_o        (reg0),
      .reg1_o        (reg1),
      .reg2_o        (reg2),
      .reg3_o        (reg3)
   );

   function automatic logic [31:0] dut_reg(input int i);
      case (i)
         0:       return reg0;
         1:       return reg1;
         2:       return reg2;
         default: return reg3;
      endcase
   endfunction

   // Byte-masked merge via a full-width mask.
   function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] mask;
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      bit aw_done, w_done, aw_hs, w_hs;
      int n;
      awaddr = addr; awvalid = 1'b1;
      wdata  = data; wstrb   = strb; wvalid = 1'b1;
      aw_done = 0; w_done = 0; n = 0;
      while (!(aw_done && w_done) && n < TIMEOUT) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         n++;
         if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
         if (w_hs)  begin w_done  = 1; wvalid  = 1'b0; end
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!(aw_done && w_done)) begin
         checks++; errors++;
         $display("FAIL write_handshake_timeout addr=%h", addr);
      end
      bready = 1'b1; n = 0;
      while (!bvalid && n < TIMEOUT) begin tick(); n++; end
      resp = bresp;
      if (!bvalid) begin
         checks++; errors++;
         $display("FAIL bvalid_timeout addr=%h", addr);
         resp = 2'bxx;
      end
      tick();
      bready = 1'b0;
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit hs;
      int n;
      araddr = addr; arvalid = 1'b1; hs = 0; n = 0;
      while (!hs && n < TIMEOUT) begin
         hs = arready;
         tick();
         n++;
      end
      arvalid = 1'b0;
      checks++;
      if (!hs) begin
         errors++;
         $display("FAIL arready_timeout addr=%h", addr);
      end else if (rvalid !== 1'b1) begin
         errors++;
         $display("FAIL read_latency addr=%h rvalid=%b expected 1", addr, rvalid);
      end
      data = rdata; resp = rresp;
      rready = 1'b1;
      tick();
      rready = 1'b0;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
         errors++;
         $display("FAIL reset_handshake got aw/w/ar/b/r=%b expected 00000",
                  {awready, wready, arready, bvalid, rvalid});
      end
      checks++;
      if ({reg0, reg1, reg2, reg3, rdata, bresp, rresp} !== '0) begin
         errors++;
         $display("FAIL reset_values regs=%h %h %h %h rdata=%h bresp=%b rresp=%b expected zeros",
                  reg0, reg1, reg2, reg3, rdata, bresp, rresp);
      end
      areset = 1'b0;
      tick();
      checks++;
      if ({awready, wready, arready} !== 3'b111) begin
         errors++;
         $display("FAIL ready_after_reset got aw/w/ar=%b expected 111", {awready, wready, arready});
      end
      for (int i = 0; i < 4; i++) model_regs[i] = '0;
   endtask

   task automatic test_basic_rw();
      logic [1:0]  resp;
      logic [31:0] data;
      for (int i = 0; i < 4; i++) begin
         axi_write(5'(4 * i), 32'(i + 1), 4'hF, resp);
         model_regs[i] = 32'(i + 1);
         checks++;
         if (resp !== OKAY) begin
            errors++;
            $display("FAIL basic_bresp reg%0d got %b expected %b", i, resp, OKAY);
         end
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(5'(4 * i), data, resp);
         checks++;
         if (data !== 32'(i + 1) || resp !== OKAY) begin
            errors++;
            $display("FAIL basic_read reg%0d got %h/%b expected %h/%b", i, data, resp, i + 1, OKAY);
         end
      end
   endtask

   task automatic test_w_before_aw();
      int n, bcount;
      bit hs;
      wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1; hs = 0; n = 0;
      while (!hs && n < TIMEOUT) begin hs = wready; tick(); n++; end
      wvalid = 1'b0;
      repeat (3) tick();
      checks++;
      if (bvalid !== 1'b0 || reg1 !== model_regs[1]) begin
         errors++;
         $display("FAIL w_only_no_commit bvalid=%b reg1=%h expected 0/%h", bvalid, reg1, model_regs[1]);
      end
      awaddr = 5'h04; awvalid = 1'b1; hs = 0; n = 0;
      while (!hs && n < TIMEOUT) begin hs = awready; tick(); n++; end
      awvalid = 1'b0;
      bready = 1'b1; bcount = 0;
      repeat (8) begin
         if (bvalid) bcount++;
         tick();
      end
      bready = 1'b0;
      model_regs[1] = 32'hA5A5A5A5;
      checks++;
      if (bcount !== 1 || reg1 !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL w_before_aw bvalid_cycles=%0d reg1=%h expected 1/a5a5a5a5", bcount, reg1);
      end
   endtask

   task automatic test_strobe();
      logic [1:0]  resp;
      logic [31:0] data;
      axi_write(5'h08, 32'hFFFFFFFF, 4'hF, resp);
      axi_write(5'h08, 32'h00000000, 4'b0101, resp);
      model_regs[2] = 32'hFF00FF00;
      axi_read(5'h08, data, resp);
      checks++;
      if (data !== 32'hFF00FF00 || resp !== OKAY) begin
         errors++;
         $display("FAIL strobe_merge got %h/%b expected ff00ff00/%b", data, resp, OKAY);
      end
   endtask

   task automatic test_unmapped(input logic [4:0] addr);
      logic [1:0]  resp;
      logic [31:0] data;
      axi_write(addr, $urandom, 4'hF, resp);
      checks++;
      if (resp !== SLVERR) begin
         errors++;
         $display("FAIL unmapped_bresp addr=%h got %b expected %b", addr, resp, SLVERR);
      end
      axi_read(addr, data, resp);
      checks++;
      if (data !== 32'h0 || resp !== SLVERR) begin
         errors++;
         $display("FAIL unmapped_read addr=%h got %h/%b expected 0/%b", addr, data, resp, SLVERR);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dut_reg(i) !== model_regs[i]) begin
            errors++;
            $display("FAIL unmapped_side_effect reg%0d got %h expected %h", i, dut_reg(i), model_regs[i]);
         end
      end
   endtask

   task automatic test_bready_stall();
      awaddr = 5'h0C; awvalid = 1'b1;
      wdata = 32'h13572468; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      model_regs[3] = 32'h13572468;
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
            errors++;
            $display("FAIL bready_stall cycle %0d bvalid/awready/wready=%b%b%b expected 100",
                     c, bvalid, awready, wready);
         end
         tick();
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      checks++;
      if ({bvalid, awready, wready} !== 3'b011 || reg3 !== 32'h13572468) begin
         errors++;
         $display("FAIL bready_release bvalid/awready/wready=%b reg3=%h expected 011/13572468",
                  {bvalid, awready, wready}, reg3);
      end
   endtask

   // AW+W accepted on one edge, AR on the commit edge: the read sees the old value.
   task automatic test_read_during_write();
      logic [31:0] old_v, new_v;
      old_v = model_regs[2];
      new_v = ~old_v;
      awaddr = 5'h08; awvalid = 1'b1; wdata = new_v; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 5'h08; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      model_regs[2] = new_v;
      checks++;
      if (rvalid !== 1'b1 || rdata !== old_v) begin
         errors++;
         $display("FAIL read_during_write rvalid=%b rdata=%h expected 1/%h", rvalid, rdata, old_v);
      end
      checks++;
      if (bvalid !== 1'b1 || reg2 !== new_v) begin
         errors++;
         $display("FAIL write_visible bvalid=%b reg2=%h expected 1/%h", bvalid, reg2, new_v);
      end
      rready = 1'b1; bready = 1'b1;
      tick();
      rready = 1'b0; bready = 1'b0;
   endtask

   task automatic test_random();
      logic [1:0]  resp, exp_resp;
      logic [31:0] data, exp_data, wd;
      logic [3:0]  strb;
      logic [4:0]  addr;
      int          idx;
      for (int it = 0; it < 60; it++) begin
         idx = $urandom_range(0, 7);
`ifdef MAX11198_AXIL_SAMPLE_EN
         if (idx == 4 || idx == 5) idx = 6;
`endif
         addr = 5'(idx * 4 + $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            wd = $urandom; strb = 4'($urandom);
            exp_resp = (idx < 4) ? OKAY : SLVERR;
            if (idx < 4) model_regs[idx] = merge(model_regs[idx], wd, strb);
            axi_write(addr, wd, strb, resp);
            checks++;
            if (resp !== exp_resp) begin
               errors++;
               $display("FAIL rand_bresp it=%0d addr=%h got %b expected %b", it, addr, resp, exp_resp);
            end
         end else begin
            exp_data = (idx < 4) ? model_regs[idx] : 32'h0;
            exp_resp = (idx < 4) ? OKAY : SLVERR;
            axi_read(addr, data, resp);
            checks++;
            if (data !== exp_data || resp !== exp_resp) begin
               errors++;
               $display("FAIL rand_read it=%0d addr=%h got %h/%b expected %h/%b",
                        it, addr, data, resp, exp_data, exp_resp);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dut_reg(i) !== model_regs[i]) begin
            errors++;
            $display("FAIL rand_reg_out reg%0d got %h expected %h", i, dut_reg(i), model_regs[i]);
         end
      end
   endtask

`ifdef MAX11198_AXIL_SAMPLE_EN
   task automatic adc_pulse(input logic [15:0] d);
      adc_data = d; adc_valid = 1'b1;
      tick();
      adc_valid = 1'b0;
   endtask

   task automatic test_sample();
      logic [1:0]  resp;
      logic [31:0] data;
      adc_pulse(16'h1234);
      tick();
      adc_pulse(16'h5678);
      tick();
      axi_read(5'h14, data, resp);
      checks++;
      if (data !== 32'h3 || resp !== OKAY) begin
         errors++;
         $display("FAIL status_after_two got %h/%b expected 3/00", data, resp);
      end
      axi_read(5'h10, data, resp);
      checks++;
      if (data !== 32'h5678 || resp !== OKAY) begin
         errors++;
         $display("FAIL sample_value got %h/%b expected 5678/00", data, resp);
      end
      axi_read(5'h14, data, resp);
      checks++;
      if (data !== 32'h2) begin
         errors++;
         $display("FAIL status_after_sample_read got %h expected 2", data);
      end
      axi_write(5'h14, 32'h2, 4'hF, resp);
      checks++;
      if (resp !== OKAY) begin
         errors++;
         $display("FAIL status_w1c_bresp got %b expected 00", resp);
      end
      axi_read(5'h14, data, resp);
      checks++;
      if (data !== 32'h0) begin
         errors++;
         $display("FAIL status_after_w1c got %h expected 0", data);
      end
   endtask
`endif

   // Reset in the middle of a write: the transaction is dropped, no response.
   task automatic test_reset_mid_transaction();
      awaddr = 5'h00; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      areset = 1'b1;
      tick();
      areset = 1'b0;
      bready = 1'b1;
      repeat (4) begin
         checks++;
         if (bvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon bvalid=%b expected 0", bvalid);
         end
         tick();
      end
      bready = 1'b0;
      for (int i = 0; i < 4; i++) model_regs[i] = '0;
      checks++;
      if ({reg0, reg1, reg2, reg3} !== 128'h0 || {awready, wready, arready} !== 3'b111) begin
         errors++;
         $display("FAIL reset_abandon_state reg0=%h ready=%b expected 0/111",
                  reg0, {awready, wready, arready});
      end
   endtask

   initial begin
      areset = 1'b1;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
`ifdef MAX11198_AXIL_SAMPLE_EN
      adc_data = '0; adc_valid = 1'b0;
`endif
      tick();
      test_reset();
      test_basic_rw();
      test_w_before_aw();
      test_strobe();
      test_unmapped(5'h18);
      test_bready_stall();
      test_read_during_write();
      test_random();
`ifdef MAX11198_AXIL_SAMPLE_EN
      test_sample();
`else
      test_unmapped(5'h10);
      test_unmapped(5'h14);
`endif
      test_reset_mid_transaction();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
